// File: rtl/ex_stage_pipe.sv
// Execute stage with a valid/ready EX/MEM output register and a multi-cycle shift-add multiplier.
// Optional flush port is enabled by defining EX_FLUSH_EN.
module ex_stage_pipe #(
  parameter int WORD     = 64,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
`ifdef EX_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] read_data1,
  input  logic [WORD-1:0] read_data2,
  input  logic [WORD-1:0] sign_extend_imm,
  input  logic [WORD-1:0] pc_in,
  input  logic            alu_src,
  input  logic [3:0]      alu_op,
  input  logic            branch_in,
  input  logic            uncondbranch_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] alu_result,
  output logic            zero,
  output logic [WORD-1:0] branch_target,
  output logic [WORD-1:0] mem_write_data,
  output logic            branch,
  output logic            uncondbranch,
  output logic            mem_read,
  output logic            mem_write
);

  localparam int MUL_CYCLES = WORD / MUL_STEP;
  localparam int CNT_W      = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t            state_r, state_next_s;
  logic              out_valid_r;
  logic [WORD-1:0]   alu_result_r, branch_target_r, mem_write_data_r;
  logic              zero_r;
  logic [3:0]        ctrl_out_r;

  logic [WORD-1:0]   acc_r, a_r, b_r, pc_r, imm_r, wdata_r;
  logic [3:0]        ctrl_mul_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              flush_s, accept_s, consume_s, in_ready_s, is_mul_s;
  logic              load_alu_s, load_mul_s, mul_start_s;
  logic [WORD-1:0]   operand_b_s, alu_s, partial_s, acc_next_s;
  logic [WORD-1:0]   result_s, target_s, wdata_s;
  logic [3:0]        ctrl_s;

`ifdef EX_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready) && !flush_s;
  assign accept_s   = in_valid && in_ready_s;
  assign consume_s  = out_valid_r && out_ready;
  assign is_mul_s   = (alu_op == 4'b1000);

  // Single-cycle ALU on the incoming operands
  always_comb begin
    operand_b_s = alu_src ? sign_extend_imm : read_data2;
    case (alu_op)
      4'b0000: alu_s = read_data1 & operand_b_s;
      4'b0001: alu_s = read_data1 | operand_b_s;
      4'b0010: alu_s = read_data1 + operand_b_s;
      4'b0110: alu_s = read_data1 - operand_b_s;
      4'b0111: alu_s = operand_b_s;
      4'b1100: alu_s = ~(read_data1 | operand_b_s);
      default: alu_s = {WORD{1'b0}};
    endcase
  end

  // One multiplier step: add the shifted multiplicand for each set bit of the current B slice
  always_comb begin
    partial_s = {WORD{1'b0}};
    for (int j = 0; j < MUL_STEP; j++) begin
      if (b_r[j]) begin
        partial_s = partial_s + (a_r << j);
      end else begin
        partial_s = partial_s;
      end
    end
    acc_next_s = acc_r + partial_s;
  end

  // Next-state and load strobes
  always_comb begin
    state_next_s = state_r;
    load_alu_s   = 1'b0;
    load_mul_s   = 1'b0;
    mul_start_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_next_s = ST_MUL;
          mul_start_s  = 1'b1;
        end else if (accept_s) begin
          load_alu_s   = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == MUL_LAST) begin
          load_mul_s   = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
    // flush aborts the multiply before it can publish
    if (flush_s) begin
      state_next_s = ST_IDLE;
      load_mul_s   = 1'b0;
      load_alu_s   = 1'b0;
      mul_start_s  = 1'b0;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Select what the EX/MEM register captures: direct ALU path or finished multiply
  always_comb begin
    if (load_mul_s) begin
      result_s = acc_next_s;
      target_s = pc_r + (imm_r << 2);
      wdata_s  = wdata_r;
      ctrl_s   = ctrl_mul_r;
    end else begin
      result_s = alu_s;
      target_s = pc_in + (sign_extend_imm << 2);
      wdata_s  = read_data2;
      ctrl_s   = {branch_in, uncondbranch_in, mem_read_in, mem_write_in};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Multiplier working registers and latched instruction fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r      <= {WORD{1'b0}};
      a_r        <= {WORD{1'b0}};
      b_r        <= {WORD{1'b0}};
      pc_r       <= {WORD{1'b0}};
      imm_r      <= {WORD{1'b0}};
      wdata_r    <= {WORD{1'b0}};
      ctrl_mul_r <= 4'b0000;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (mul_start_s) begin
      acc_r      <= {WORD{1'b0}};
      a_r        <= read_data1;
      b_r        <= operand_b_s;
      pc_r       <= pc_in;
      imm_r      <= sign_extend_imm;
      wdata_r    <= read_data2;
      ctrl_mul_r <= {branch_in, uncondbranch_in, mem_read_in, mem_write_in};
      cnt_r      <= {CNT_W{1'b0}};
    end else if (state_r == ST_MUL) begin
      acc_r      <= acc_next_s;
      a_r        <= a_r << MUL_STEP;
      b_r        <= b_r >> MUL_STEP;
      cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_r      <= acc_r;
      cnt_r      <= cnt_r;
    end
  end

  // EX/MEM data and control register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_r     <= {WORD{1'b0}};
      zero_r           <= 1'b0;
      branch_target_r  <= {WORD{1'b0}};
      mem_write_data_r <= {WORD{1'b0}};
      ctrl_out_r       <= 4'b0000;
    end else if (load_alu_s || load_mul_s) begin
      alu_result_r     <= result_s;
      zero_r           <= (result_s == {WORD{1'b0}});
      branch_target_r  <= target_s;
      mem_write_data_r <= wdata_s;
      ctrl_out_r       <= ctrl_s;
    end else begin
      alu_result_r     <= alu_result_r;
      zero_r           <= zero_r;
    end
  end

  // EX/MEM valid flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         out_valid_r <= 1'b0;
    else if (flush_s)                  out_valid_r <= 1'b0;
    else if (load_alu_s || load_mul_s) out_valid_r <= 1'b1;
    else if (consume_s)                out_valid_r <= 1'b0;
    else                               out_valid_r <= out_valid_r;
  end

  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_r;
  assign alu_result     = alu_result_r;
  assign zero           = zero_r;
  assign branch_target  = branch_target_r;
  assign mem_write_data = mem_write_data_r;
  assign branch         = ctrl_out_r[3];
  assign uncondbranch   = ctrl_out_r[2];
  assign mem_read       = ctrl_out_r[1];
  assign mem_write      = ctrl_out_r[0];

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed self-checking bench for ex_stage_pipe (WORD=64, MUL_STEP=1).
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
`ifdef EX_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] read_data1, read_data2, sign_extend_imm, pc_in;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        branch_in, uncondbranch_in, mem_read_in, mem_write_in;
  logic [63:0] alu_result, branch_target, mem_write_data;
  logic        zero, branch, uncondbranch, mem_read, mem_write;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage_pipe #(.WORD(64), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset),
`ifdef EX_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready),
    .read_data1(read_data1), .read_data2(read_data2),
    .sign_extend_imm(sign_extend_imm), .pc_in(pc_in),
    .alu_src(alu_src), .alu_op(alu_op),
    .branch_in(branch_in), .uncondbranch_in(uncondbranch_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
    .mem_write_data(mem_write_data), .branch(branch), .uncondbranch(uncondbranch),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                       input logic [63:0] pc, input logic src, input logic [3:0] op,
                       input logic [3:0] ctl);
    read_data1 = a; read_data2 = b; sign_extend_imm = imm; pc_in = pc;
    alu_src = src; alu_op = op;
    {branch_in, uncondbranch_in, mem_read_in, mem_write_in} = ctl;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 4'b0000, 4'b0000);
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (alu_result !== 64'd0) begin n_fail++; $display("FAIL reset_alu_result: got %h want 0", alu_result); end
    n_checks++; if ({zero, branch, uncondbranch, mem_read, mem_write} !== 5'b00000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {zero, branch, uncondbranch, mem_read, mem_write}); end
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    drive(64'd5, 64'd7, 64'd99, 64'd0, 1'b0, 4'b0010, 4'b0010);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_checks++; if (alu_result !== 64'd12) begin n_fail++; $display("FAIL add_result: got %0d want 12", alu_result); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", zero); end
    n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL add_mem_read: got %b want 1", mem_read); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_consumed: got %b want 0", out_valid); end
    n_checks++; if (alu_result !== 64'd12) begin n_fail++; $display("FAIL add_hold: got %0d want 12", alu_result); end
  endtask

  task automatic test_sub();
    drive(64'd3, 64'd9, 64'd3, 64'd0, 1'b1, 4'b0110, 4'b0001);
    in_valid = 1'b1;
    step();
    n_checks++; if (alu_result !== 64'd0) begin n_fail++; $display("FAIL sub_result: got %h want 0", alu_result); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b want 1", zero); end
    n_checks++; if (mem_write_data !== 64'd9) begin n_fail++; $display("FAIL sub_wdata: got %h want 9", mem_write_data); end
    n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL sub_mem_write: got %b want 1", mem_write); end
    drive(64'd0, 64'd1, 64'd0, 64'd0, 1'b0, 4'b0110, 4'b0000);
    step();
    in_valid = 1'b0;
    n_checks++; if (alu_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sub_wrap: got %h want ffffffffffffffff", alu_result); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL sub_wrap_zero: got %b want 0", zero); end
    step();
  endtask

  task automatic test_branch();
    drive(64'h10, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 1'b1, 4'b0010, 4'b1000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (branch_target !== 64'hF0) begin n_fail++; $display("FAIL br_target: got %h want f0", branch_target); end
    n_checks++; if (branch !== 1'b1) begin n_fail++; $display("FAIL br_branch: got %b want 1", branch); end
    n_checks++; if (alu_result !== 64'hC) begin n_fail++; $display("FAIL br_result: got %h want c", alu_result); end
    n_checks++; if (mem_write_data !== 64'hABCD) begin n_fail++; $display("FAIL br_wdata: got %h want abcd", mem_write_data); end
    step();
  endtask

  task automatic test_logic_ops();
    logic [3:0]  ops [5] = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0011};
    logic [63:0] exp [5] = '{64'hF000, 64'hFFF0, 64'hFFFF_FFFF_FFFF_000F, 64'hFF00, 64'h0};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(64'hF0F0, 64'hFF00, 64'h1, 64'h0, 1'b0, ops[i], 4'b0100);
      step();
      n_checks++; if (alu_result !== exp[i] || out_valid !== 1'b1) begin n_fail++; $display("FAIL logic_op%0d: got %h valid %b want %h valid 1", i, alu_result, out_valid, exp[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 4'b0010, 4'b0000);
    in_valid = 1'b1;
    step();
    drive(64'd10, 64'd20, 64'd0, 64'd0, 1'b0, 4'b0010, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b1 || alu_result !== 64'd3 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_c%0d: got valid %b res %0d in_ready %b want 1 3 0", i, out_valid, alu_result, in_ready); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || alu_result !== 64'd30) begin n_fail++; $display("FAIL b2b_first: got valid %b res %0d want 1 30", out_valid, alu_result); end
    drive(64'd100, 64'd1, 64'd0, 64'd0, 1'b0, 4'b0010, 4'b0000);
    step();
    n_checks++; if (out_valid !== 1'b1 || alu_result !== 64'd101) begin n_fail++; $display("FAIL b2b_second: got valid %b res %0d want 1 101", out_valid, alu_result); end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_mul();
    int n;
    int low;
    drive(64'h1_0000_0001, 64'd3, 64'd0, 64'h40, 1'b0, 4'b1000, 4'b0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0; low = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (in_ready === 1'b0) low++;
      step();
      n++;
    end
    n_checks++; if (n != 64) begin n_fail++; $display("FAIL mul_latency: got %0d cycles want 64", n); end
    n_checks++; if (low != 64) begin n_fail++; $display("FAIL mul_in_ready_low: got %0d cycles want 64", low); end
    n_checks++; if (alu_result !== 64'h3_0000_0003) begin n_fail++; $display("FAIL mul_result: got %h want 300000003", alu_result); end
    n_checks++; if (mem_write_data !== 64'd3 || zero !== 1'b0) begin n_fail++; $display("FAIL mul_wdata_zero: got %h %b want 3 0", mem_write_data, zero); end
  endtask

  task automatic test_mul_reset();
    int seen;
    step();
    drive(64'd5, 64'd6, 64'd0, 64'd0, 1'b0, 4'b1000, 4'b0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (19) step();
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || alu_result !== 64'd0) begin n_fail++; $display("FAIL mulrst_clear: got valid %b res %h want 0 0", out_valid, alu_result); end
    step();
    reset = 1'b0;
    seen = 0;
    repeat (70) begin
      step();
      if (out_valid !== 1'b0) seen = 1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mulrst_no_result: got %0d want 0", seen); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mulrst_in_ready: got %b want 1", in_ready); end
  endtask

`ifdef EX_FLUSH_EN
  task automatic test_flush();
    drive(64'd7, 64'd7, 64'd0, 64'd0, 1'b0, 4'b1000, 4'b0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_abort: got valid %b in_ready %b want 0 1", out_valid, in_ready); end
    drive(64'd2, 64'd2, 64'd0, 64'd0, 1'b0, 4'b0010, 4'b0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || alu_result !== 64'd4) begin n_fail++; $display("FAIL flush_next_add: got valid %b res %0d want 1 4", out_valid, alu_result); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_branch();
    test_logic_ops();
    test_stall();
    test_back_to_back();
    test_mul();
    test_mul_reset();
`ifdef EX_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
